// File: rtl/pifo_tb_phase_controller_if.sv
// pifo_tb_phase_controller_if: shared PIFO enqueue port bundle.
// The master side arbitrates; the slave side is generators plus PIFO.
interface pifo_tb_phase_controller_if #(
  parameter int NUM_TG = 4,
  parameter int PTR_W  = 10,
  parameter int PRIO_W = 16
);
  logic                     i__pifo_ready;
  logic [NUM_TG-1:0]        i__tg_valid;
  logic [NUM_TG*PTR_W-1:0]  i__tg_pointer;
  logic [NUM_TG*PRIO_W-1:0] i__tg_priority;
  logic [NUM_TG-1:0]        o__tg_ready;
  logic                     o__enq_valid;
  logic [PTR_W-1:0]         o__enq_pointer;
  logic [PRIO_W-1:0]        o__enq_priority;

  modport master (
    input  i__pifo_ready, i__tg_valid,
    input  i__tg_pointer, i__tg_priority,
    output o__tg_ready, o__enq_valid,
    output o__enq_pointer, o__enq_priority
  );

  modport slave (
    output i__pifo_ready, i__tg_valid,
    output i__tg_pointer, i__tg_priority,
    input  o__tg_ready, o__enq_valid,
    input  o__enq_pointer, o__enq_priority
  );
endinterface

// File: rtl/pifo_tb_phase_controller.sv
// pifo_tb_phase_controller: PIFO bench phase sequencer and enqueue arbiter.
// Define PHASE_CTRL_STATS_EN for drain-length and max-wait statistics.
module pifo_tb_phase_controller #(
  parameter int NUM_TG        = 4,
  parameter int CNT_W         = 16,
  parameter int PTR_W         = 10,
  parameter int PRIO_W        = 16,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i__start,
  input  logic [CNT_W-1:0] i__gen_cycles,
  input  logic             i__pifo_empty,
  input  logic             i__deq_valid,
  pifo_tb_phase_controller_if.master enq,
  output logic             o__generate_phase,
  output logic [CNT_W-1:0] o__phase_count,
  output logic             o__deq_req,
  output logic [CNT_W-1:0] o__enq_count,
  output logic [CNT_W-1:0] o__deq_count,
  output logic             o__done,
  output logic             o__timeout
`ifdef PHASE_CTRL_STATS_EN
  ,
  output logic [CNT_W-1:0] o__drain_cycles,
  output logic [CNT_W-1:0] o__max_wait
`endif
);

  typedef enum logic [1:0] {IDLE, GEN, DRAIN, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

  state_t state, state_n;

  logic              start_q;
  logic [NUM_TG-1:0] grant;
  logic [CNT_W-1:0]  gen_len;
  logic [CNT_W-1:0]  phase;
  logic [CNT_W-1:0]  enq_cnt;
  logic [CNT_W-1:0]  deq_cnt;
  logic              tout;

  logic              gen;
  logic              start_edge;
  logic              gen_end;
  logic              complete;
  logic              expire;
  logic [NUM_TG-1:0] take;
  logic [PTR_W-1:0]  ptr_mux;
  logic [PRIO_W-1:0] prio_mux;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  assign gen        = (state == GEN);
  assign start_edge = i__start & ~start_q;
  assign gen_end    = (phase == gen_len - 1'b1);
  assign complete   = (deq_cnt == enq_cnt) && i__pifo_empty;
  assign expire     = (phase == TO_LAST) && !i__deq_valid;

  assign enq.o__tg_ready = grant & {NUM_TG{enq.i__pifo_ready & gen}};
  assign take            = enq.i__tg_valid & enq.o__tg_ready;

  // Grant is one-hot, so OR-ing the gated lanes is the mux.
  always_comb begin
    ptr_mux  = '0;
    prio_mux = '0;
    for (int k = 0; k < NUM_TG; k++) begin
      if (take[k]) begin
        ptr_mux  = ptr_mux  | enq.i__tg_pointer[k*PTR_W +: PTR_W];
        prio_mux = prio_mux | enq.i__tg_priority[k*PRIO_W +: PRIO_W];
      end
    end
  end

  assign enq.o__enq_valid    = |take;
  assign enq.o__enq_pointer  = ptr_mux;
  assign enq.o__enq_priority = prio_mux;

  assign o__generate_phase = gen;
  assign o__phase_count    = phase;
  assign o__deq_req        = (state == DRAIN) && !i__pifo_empty;
  assign o__enq_count      = enq_cnt;
  assign o__deq_count      = deq_cnt;
  assign o__done           = (state == DONE);
  assign o__timeout        = tout;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (start_edge)
          state_n = (i__gen_cycles == '0) ? DRAIN : GEN;
      GEN:
        if (gen_end) state_n = DRAIN;
      DRAIN:
        if (complete || expire) state_n = DONE;
      DONE:
        if (!i__start) state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_q <= 1'b0;
      grant   <= NUM_TG'(1);
      gen_len <= '0;
      phase   <= '0;
      enq_cnt <= '0;
      deq_cnt <= '0;
      tout    <= 1'b0;
    end else begin
      start_q <= i__start;
      if (gen && enq.i__pifo_ready)
        grant <= {grant[NUM_TG-2:0], grant[NUM_TG-1]};
      unique case (state)
        IDLE:
          if (start_edge) begin
            gen_len <= i__gen_cycles;
            phase   <= '0;
            enq_cnt <= '0;
            deq_cnt <= '0;
            tout    <= 1'b0;
          end
        GEN: begin
          phase <= gen_end ? '0 : sat_inc(phase);
          if (enq.o__enq_valid) enq_cnt <= sat_inc(enq_cnt);
          if (i__deq_valid)     deq_cnt <= sat_inc(deq_cnt);
        end
        DRAIN: begin
          phase <= i__deq_valid ? '0 : sat_inc(phase);
          if (i__deq_valid)        deq_cnt <= sat_inc(deq_cnt);
          if (expire && !complete) tout    <= 1'b1;
        end
        DONE:
          if (!i__start) tout <= 1'b0;
      endcase
    end
  end

`ifdef PHASE_CTRL_STATS_EN
  logic [NUM_TG-1:0][CNT_W-1:0] wait_run, wait_nx;
  logic [CNT_W-1:0]             drain_cyc, max_w, peak;

  always_comb begin
    wait_nx = wait_run;
    peak    = max_w;
    for (int k = 0; k < NUM_TG; k++) begin
      wait_nx[k] = (enq.i__tg_valid[k] & ~enq.o__tg_ready[k])
                 ? sat_inc(wait_run[k]) : '0;
      if (wait_nx[k] > peak) peak = wait_nx[k];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_run  <= '0;
      drain_cyc <= '0;
      max_w     <= '0;
    end else if (state == IDLE && start_edge) begin
      wait_run  <= '0;
      drain_cyc <= '0;
      max_w     <= '0;
    end else if (gen) begin
      wait_run <= wait_nx;
      max_w    <= peak;
    end else if (state == DRAIN) begin
      drain_cyc <= sat_inc(drain_cyc);
    end
  end

  assign o__drain_cycles = drain_cyc;
  assign o__max_wait     = max_w;
`endif

endmodule

// File: tb/tb_pifo_tb_phase_controller.sv
// tb_pifo_tb_phase_controller: randomized bench with a behavioural
// arbiter/PIFO model for the phase controller.
module tb_pifo_tb_phase_controller;
  localparam int NUM_TG = 4;
  localparam int CNT_W  = 16;
  localparam int PTR_W  = 10;
  localparam int PRIO_W = 16;
  localparam int TO     = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] gen_cycles = '0;
  logic             pifo_empty = 1'b1;
  logic             deq_valid = 1'b0;
  logic             generate_phase;
  logic [CNT_W-1:0] phase_count;
  logic             deq_req;
  logic [CNT_W-1:0] enq_count;
  logic [CNT_W-1:0] deq_count;
  logic             done;
  logic             timeout;

  int n_cmp = 0;
  int n_bad = 0;
  int g     = 0;
  int fill  = 0;

  always #5 clk = ~clk;

  pifo_tb_phase_controller_if #(
    .NUM_TG(NUM_TG), .PTR_W(PTR_W), .PRIO_W(PRIO_W)
  ) bus ();

  pifo_tb_phase_controller #(
    .NUM_TG(NUM_TG), .CNT_W(CNT_W), .PTR_W(PTR_W),
    .PRIO_W(PRIO_W), .DRAIN_TIMEOUT(TO)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .i__start         (start),
    .i__gen_cycles    (gen_cycles),
    .i__pifo_empty    (pifo_empty),
    .i__deq_valid     (deq_valid),
    .enq              (bus),
    .o__generate_phase(generate_phase),
    .o__phase_count   (phase_count),
    .o__deq_req       (deq_req),
    .o__enq_count     (enq_count),
    .o__deq_count     (deq_count),
    .o__done          (done),
    .o__timeout       (timeout)
  );

  task automatic drive_gens(input bit rdy, input logic [NUM_TG-1:0] v);
    bus.i__pifo_ready  = rdy;
    bus.i__tg_valid    = v;
    bus.i__tg_pointer  = (NUM_TG*PTR_W)'({$urandom(), $urandom()});
    bus.i__tg_priority = (NUM_TG*PRIO_W)'({$urandom(), $urandom()});
  endtask

  // mode 0: always ready, all valid; 1: ready low on cycles 3-4; 2: random
  task automatic run_test(input int n, input int mode, input bit drop,
                          input int hold, output int enq_n,
                          output bit tout_n);
    int exp_enq = 0, exp_deq = 0, exp_ph = 0;
    bit pend = 0, fin = 0, rdy, cmpl, expr, tout_exp = 0;
    logic [NUM_TG-1:0] v, erdy;
    logic [PTR_W-1:0]  ep;
    logic [PRIO_W-1:0] epr;
    logic [63:0] obs, exp;
    @(negedge clk);
    start = 1'b1;
    gen_cycles = CNT_W'(n);
    deq_valid = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? !(c == 2 || c == 3)
          : ($urandom_range(0, 3) != 0);
      v = (mode == 2) ? NUM_TG'($urandom()) : '1;
      drive_gens(rdy, v);
      deq_valid = 1'b0;
      pifo_empty = (fill == 0);
      #1;
      erdy = rdy ? NUM_TG'(1 << g) : '0;
      ep   = (rdy && v[g]) ? bus.i__tg_pointer[g*PTR_W +: PTR_W] : '0;
      epr  = (rdy && v[g]) ? bus.i__tg_priority[g*PRIO_W +: PRIO_W] : '0;
      obs = {generate_phase, phase_count, bus.o__tg_ready, bus.o__enq_valid,
             bus.o__enq_pointer, bus.o__enq_priority, enq_count};
      exp = {1'b1, CNT_W'(c), erdy, rdy && v[g], ep, epr, CNT_W'(exp_enq)};
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL gen_cycle n=%0d c=%0d got %h want %h", n, c, obs, exp);
      end
      if (rdy && v[g]) begin exp_enq++; fill++; end
      if (rdy) g = (g + 1) % NUM_TG;
    end
    if (drop && fill > 0) fill--;
    for (int c = 0; c < 400 && !fin; c++) begin
      @(negedge clk);
      drive_gens(1'($urandom()), NUM_TG'($urandom()));
      deq_valid = pend;
      if (pend) fill--;
      pifo_empty = (fill == 0);
      #1;
      obs = 64'({generate_phase, deq_req, phase_count, deq_count, enq_count,
                 done, bus.o__tg_ready, bus.o__enq_valid});
      exp = 64'({1'b0, !pifo_empty, CNT_W'(exp_ph), CNT_W'(exp_deq),
                 CNT_W'(exp_enq), 1'b0, NUM_TG'(0), 1'b0});
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL drain_cycle n=%0d c=%0d got %h want %h", n, c, obs, exp);
      end
      cmpl = (exp_deq == exp_enq) && pifo_empty;
      expr = (exp_ph == TO - 1) && !deq_valid;
      if (deq_valid) begin exp_deq++; exp_ph = 0; end
      else exp_ph++;
      pend = !pifo_empty;
      if (cmpl || expr) begin fin = 1; tout_exp = !cmpl; end
    end
    n_cmp++;
    if (!fin) begin
      n_bad++;
      $display("FAIL drain_bound got unfinished want finished within 400");
    end
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      deq_valid = 1'($urandom());
      pifo_empty = 1'b1;
      #1;
      obs = 64'({done, timeout, generate_phase, deq_req, enq_count, deq_count});
      exp = 64'({1'b1, tout_exp, 1'b0, 1'b0, CNT_W'(exp_enq), CNT_W'(exp_deq)});
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL done_hold c=%0d got %h want %h", c, obs, exp);
      end
    end
    @(negedge clk);
    start = 1'b0;
    deq_valid = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++;
    if ({done, timeout} !== 2'b00) begin
      n_bad++;
      $display("FAIL done_release got %b want 00", {done, timeout});
    end
    enq_n = exp_enq;
    tout_n = tout_exp;
  endtask

  task automatic test_reset();
    logic [127:0] z;
    drive_gens(1'b1, '1);
    #2;
    z = 128'({generate_phase, phase_count, bus.o__tg_ready, bus.o__enq_valid,
              bus.o__enq_pointer, bus.o__enq_priority, deq_req, enq_count,
              deq_count, done, timeout});
    n_cmp++;
    if (z !== '0) begin
      n_bad++;
      $display("FAIL reset_state got %h want 0", z);
    end
    @(negedge clk);
    reset = 1'b1;
    g = 0;
    fill = 0;
  endtask

  task automatic test_grant_sequence();
    int e; bit t;
    run_test(8, 0, 0, 3, e, t);
    n_cmp++;
    if (e != 8 || t != 0) begin
      n_bad++;
      $display("FAIL grant_seq got enq=%0d tout=%0d want enq=8 tout=0", e, t);
    end
  endtask

  task automatic test_ready_stall();
    int e; bit t;
    run_test(8, 1, 0, 2, e, t);
    n_cmp++;
    if (e != 6 || t != 0 || deq_count !== 16'd6) begin
      n_bad++;
      $display("FAIL ready_stall got enq=%0d deq=%0d tout=%0d want 6 6 0",
               e, deq_count, t);
    end
  endtask

  task automatic test_drain_drop();
    int e; bit t;
    run_test(6, 0, 1, 2, e, t);
    n_cmp++;
    if (e != 6 || t != 1 || deq_count !== 16'd5) begin
      n_bad++;
      $display("FAIL drain_drop got enq=%0d deq=%0d tout=%0d want 6 5 1",
               e, deq_count, t);
    end
  endtask

  task automatic test_zero_gen();
    int e; bit t;
    run_test(0, 0, 0, 1, e, t);
    n_cmp++;
    if (e != 0 || t != 0) begin
      n_bad++;
      $display("FAIL zero_gen got enq=%0d tout=%0d want 0 0", e, t);
    end
  endtask

  task automatic test_reset_mid_generate();
    int e; bit t;
    logic [127:0] z;
    @(negedge clk);
    start = 1'b1;
    gen_cycles = 16'd8;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive_gens(1'b1, '1);
      pifo_empty = (fill == 0);
      fill++;
    end
    #1;
    reset = 1'b0;
    #1;
    z = 128'({generate_phase, phase_count, bus.o__tg_ready, bus.o__enq_valid,
              bus.o__enq_pointer, bus.o__enq_priority, deq_req, enq_count,
              deq_count, done, timeout});
    n_cmp++;
    if (z !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_gen got %h want 0", z);
    end
    start = 1'b0;
    g = 0;
    fill = 0;
    @(negedge clk);
    reset = 1'b1;
    run_test(8, 0, 0, 1, e, t);
    n_cmp++;
    if (e != 8) begin
      n_bad++;
      $display("FAIL restart_after_reset got enq=%0d want 8", e);
    end
  endtask

  task automatic test_random();
    int e; bit t;
    for (int i = 0; i < 10; i++)
      run_test($urandom_range(1, 12), 2, 1'($urandom()),
               $urandom_range(1, 4), e, t);
  endtask

  initial begin
    drive_gens(1'b0, '0);
    test_reset();
    test_grant_sequence();
    test_ready_stall();
    test_drain_drop();
    test_zero_gen();
    test_reset_mid_generate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pifo_tb_phase_controller.md
Name: pifo_tb_phase_controller

Overview:
- Testbench-side sequencer and arbiter for the PIFO bench.
- Runs each test through its phases (IDLE, GENERATE, DRAIN, DONE) and drives the per-generator generate-phase, phase-count and ready inputs.
- During GENERATE, shares the single PIFO enqueue port among NUM_TG traffic generators using a rotating one-hot grant, and muxes the granted generator's packet onto the enqueue port.
- During DRAIN, issues dequeues until everything enqueued has come back out, or a timeout fires.

Parameters:
- NUM_TG, 4: number of traffic generators sharing the PIFO; must be at least 2.
- CNT_W, 16: width of the phase, enqueue and dequeue counters.
- PTR_W, 10: packet pointer width.
- PRIO_W, 16: priority width.
- DRAIN_TIMEOUT, 1024: consecutive DRAIN cycles without a dequeue before the test aborts.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- i__start  in  1  level; a rising edge seen in IDLE starts a test
- i__gen_cycles  in  CNT_W  GENERATE phase length in cycles; sampled on start
- i__pifo_ready  in  1  PIFO can accept an enqueue this cycle
- i__pifo_empty  in  1  PIFO holds no entries
- i__deq_valid  in  1  PIFO returned an entry this cycle
- i__tg_valid  in  NUM_TG  per-generator valid_packet_generated
- i__tg_pointer  in  NUM_TG*PTR_W  packed per-generator pointers; generator k at bits [k*PTR_W +: PTR_W]
- i__tg_priority  in  NUM_TG*PRIO_W  packed per-generator priorities, same packing
- o__generate_phase  out  1  high in GENERATE
- o__phase_count  out  CNT_W  cycles elapsed in the current phase
- o__tg_ready  out  NUM_TG  one-hot grant ANDed with i__pifo_ready
- o__enq_valid  out  1  OR of (i__tg_valid & o__tg_ready)
- o__enq_pointer  out  PTR_W  granted generator's pointer
- o__enq_priority  out  PRIO_W  granted generator's priority
- o__deq_req  out  1  dequeue request
- o__enq_count  out  CNT_W  packets enqueued this test
- o__deq_count  out  CNT_W  packets dequeued this test
- o__done  out  1  test finished
- o__timeout  out  1  drain aborted

Behaviour:
- Reset values: state=IDLE, grant=one-hot bit 0, all counters 0, all outputs 0.
- IDLE:
  - Registers i__start to detect a rising edge.
  - On the edge: clear all counters, latch i__gen_cycles, go to GENERATE.
  - Edge detected while i__gen_cycles==0: go straight to DRAIN.
- GENERATE:
  - o__generate_phase=1.
  - phase_count increments every cycle.
  - When phase_count==latched-1 (end of that cycle): phase_count<=0, go to DRAIN.
  - GENERATE therefore lasts exactly i__gen_cycles cycles.
- Grant rotation:
  - Grant register rotates left by one (bit NUM_TG-1 wraps to bit 0) in every GENERATE cycle where i__pifo_ready=1.
  - Grant holds when i__pifo_ready=0.
  - Grant is retained across tests, not re-reset.
- Enqueue path:
  - o__tg_ready = grant & {NUM_TG{i__pifo_ready & generate_phase}}.
  - Enqueue outputs are combinational from the inputs, zero latency.
  - o__enq_pointer and o__enq_priority are 0 when o__enq_valid=0.
  - o__enq_count increments on o__enq_valid.
  - A generator asserting valid without a grant is ignored and not counted.
- DRAIN:
  - o__deq_req = !i__pifo_empty.
  - o__deq_count increments on i__deq_valid.
  - A late i__deq_valid arriving in GENERATE is also counted.
  - phase_count counts cycles since the last dequeue and resets on i__deq_valid.
  - Go to DONE when deq_count==enq_count and i__pifo_empty=1.
  - Go to DONE with o__timeout=1 when phase_count reaches DRAIN_TIMEOUT-1 without a dequeue.
  - If the completion and timeout conditions hit in the same cycle, completion wins and o__timeout stays 0.
- DONE:
  - o__done=1; counters frozen.
  - When i__start=0: go to IDLE; o__done and o__timeout clear on that transition.
- Counter width: counters saturate at all-ones and never wrap.
- Reset mid-test: returns to IDLE with outputs as above within the asserted cycle (asynchronous).

Optional Feature:
- Macro: PHASE_CTRL_STATS_EN.
- When defined, adds the following outputs, each cleared on start and frozen in DONE:
  - o__drain_cycles (CNT_W): total DRAIN length, saturating.
  - o__max_wait (CNT_W): longest run of cycles any single generator asserted valid without being granted.
- When undefined, these ports and their logic are absent.

Test Plan:
- NUM_TG=4, gen_cycles=8, pifo_ready=1, all tg_valid=1 -> grant sequence 1,2,4,8,1,2,4,8; enq_count=8; GENERATE high exactly 8 cycles.
- Same setup, pifo_ready=0 on cycles 3-4 -> grant holds at 4 for those cycles; enq_count=6.
- Drain with 6 entries, deq_valid one cycle after each deq_req -> deq_count=6, done=1, timeout=0.
- Drain where the PIFO drops one entry (empty with deq_count=5 vs enq_count=6), DRAIN_TIMEOUT=16 -> done and timeout assert 16 cycles after the last dequeue.
- Reset asserted during GENERATE cycle 5 -> all outputs 0 immediately; a new start gives a full 8-cycle GENERATE with counters from 0.
- start held high through DONE -> remains in DONE; start low -> IDLE next cycle; done=0.
